// File: rtl/rll_pkg.sv
// RLL(2,7) code tables, length encoding and the codeword match helper
// shared by the decoder and its serializer.
package rll_pkg;

  localparam int CW_W   = 8;
  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    LEN_NONE = 3'd0,
    LEN2     = 3'd2,
    LEN3     = 3'd3,
    LEN4     = 3'd4
  } rll_len_e;

  localparam logic [3:0] CW4_A = 4'b1000;     localparam logic [3:0] D4_A = 4'b0011;
  localparam logic [3:0] CW4_B = 4'b0100;     localparam logic [3:0] D4_B = 4'b0010;
  localparam logic [5:0] CW6_A = 6'b001000;   localparam logic [3:0] D6_A = 4'b0011;
  localparam logic [5:0] CW6_B = 6'b100100;   localparam logic [3:0] D6_B = 4'b0010;
  localparam logic [5:0] CW6_C = 6'b000100;   localparam logic [3:0] D6_C = 4'b0000;
  localparam logic [7:0] CW8_A = 8'b00001000; localparam logic [3:0] D8_A = 4'b0011;
  localparam logic [7:0] CW8_B = 8'b00100100; localparam logic [3:0] D8_B = 4'b0010;

  typedef struct packed {
    logic                hit;
    logic [DATA_W-1:0]   word;
    rll_len_e            len;
  } rll_match_t;

  // Only the newest cnt channel bits take part; the code is prefix-free.
  function automatic rll_match_t rll_match(input logic [CW_W-1:0] cw, input logic [3:0] cnt);
    rll_match_t m;
    m.hit  = 1'b0;
    m.word = 4'd0;
    m.len  = LEN_NONE;
    case (cnt)
      4'd4: begin
        if (cw[3:0] == CW4_A) begin
          m = '{hit: 1'b1, word: D4_A, len: LEN2};
        end else if (cw[3:0] == CW4_B) begin
          m = '{hit: 1'b1, word: D4_B, len: LEN2};
        end else begin
          m.hit = 1'b0;
        end
      end
      4'd6: begin
        if (cw[5:0] == CW6_A) begin
          m = '{hit: 1'b1, word: D6_A, len: LEN3};
        end else if (cw[5:0] == CW6_B) begin
          m = '{hit: 1'b1, word: D6_B, len: LEN3};
        end else if (cw[5:0] == CW6_C) begin
          m = '{hit: 1'b1, word: D6_C, len: LEN3};
        end else begin
          m.hit = 1'b0;
        end
      end
      4'd8: begin
        if (cw == CW8_A) begin
          m = '{hit: 1'b1, word: D8_A, len: LEN4};
        end else if (cw == CW8_B) begin
          m = '{hit: 1'b1, word: D8_B, len: LEN4};
        end else begin
          m.hit = 1'b0;
        end
      end
      default: m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/decoder_rll_serializer.sv
// Parallel-to-serial stage: emits a decoded word MSB-first, one bit per cycle;
// a reload overwrites whatever is still draining.
module rll_bit_serializer
  import rll_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  rll_len_e          len_i,
  output logic              bit_o,
  output logic              bit_valid_o
);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [2:0]        rem_q, rem_d;
  logic              bit_q, bit_d;
  logic              bit_valid_q, bit_valid_d;
  logic [DATA_W-1:0] align_s;

  // Left-align the word, then shift out from bit 3.
  always_comb begin
    sh_d        = sh_q;
    rem_d       = rem_q;
    bit_d       = 1'b0;
    bit_valid_d = 1'b0;
    case (len_i)
      LEN2:    align_s = {word_i[1:0], 2'b00};
      LEN3:    align_s = {word_i[2:0], 1'b0};
      LEN4:    align_s = word_i;
      default: align_s = 4'd0;
    endcase
    if (load_i && (len_i != LEN_NONE)) begin
      bit_d       = align_s[3];
      bit_valid_d = 1'b1;
      sh_d        = {align_s[2:0], 1'b0};
      rem_d       = 3'(len_i) - 3'd1;
    end else if (rem_q != 3'd0) begin
      bit_d       = sh_q[3];
      bit_valid_d = 1'b1;
      sh_d        = {sh_q[2:0], 1'b0};
      rem_d       = rem_q - 3'd1;
    end else begin
      rem_d = 3'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q        <= 4'd0;
      rem_q       <= 3'd0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      rem_q       <= rem_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign bit_o       = bit_q;
  assign bit_valid_o = bit_valid_q;

endmodule

// File: rtl/decoder_rll.sv
// RLL(2,7) receive decoder: transition detect, codeword framing and match,
// saturating error count, followed by a serial re-emitter of each word.
module decoder_rll
  import rll_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 line_i,
  output logic [3:0]           word_o,
  output logic [2:0]           len_o,
  output logic                 word_valid_o,
  output logic                 bit_o,
  output logic                 bit_valid_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  logic                 line_q;
  logic [CW_W-1:0]      cw_q, cw_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DATA_W-1:0]    word_q, word_d;
  rll_len_e             len_q, len_d;
  logic                 word_valid_q, word_valid_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 t_s;
  logic [CW_W-1:0]      cw_sh_s;
  logic [3:0]           cnt_inc_s;
  rll_match_t           m_s;

  // Match is evaluated on the post-shift codeword so a word completes on the edge that samples its last bit.
  always_comb begin
    t_s          = line_i ^ line_q;
    cw_sh_s      = {cw_q[CW_W-2:0], t_s};
    cnt_inc_s    = cnt_q + 4'd1;
    m_s          = rll_match(cw_sh_s, cnt_inc_s);
    cw_d         = cw_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    len_d        = len_q;
    word_valid_d = 1'b0;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;
    if (!en_i) begin
      cw_d  = 8'd0;
      cnt_d = 4'd0;
    end else if (m_s.hit) begin
      word_d       = m_s.word;
      len_d        = m_s.len;
      word_valid_d = 1'b1;
      cw_d         = 8'd0;
      cnt_d        = 4'd0;
    end else if (cnt_inc_s == 4'd8) begin
      err_d = 1'b1;
      cw_d  = 8'd0;
      cnt_d = 4'd0;
      if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      cw_d  = cw_sh_s;
      cnt_d = cnt_inc_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q       <= 1'b0;
      cw_q         <= 8'd0;
      cnt_q        <= 4'd0;
      word_q       <= 4'd0;
      len_q        <= LEN_NONE;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= {ERR_CNT_W{1'b0}};
    end else begin
      line_q       <= line_i;
      cw_q         <= cw_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      len_q        <= len_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  rll_bit_serializer u_ser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (word_valid_q),
    .word_i      (word_q),
    .len_i       (len_q),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o)
  );

  assign word_o       = word_q;
  assign len_o        = len_q;
  assign word_valid_o = word_valid_q;
  assign err_o        = err_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_decoder_rll.sv
// Scoreboard bench for decoder_rll: each codeword sent queues its expected word,
// serial bits and error pulses with the cycle they must appear in.
module tb_decoder_rll;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       line_i;
  logic [3:0] word_o;
  logic [2:0] len_o;
  logic       word_valid_o;
  logic       bit_o;
  logic       bit_valid_o;
  logic       err_o;
  logic [7:0] err_cnt_o;

  decoder_rll #(.ERR_CNT_W(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .line_i       (line_i),
    .word_o       (word_o),
    .len_o        (len_o),
    .word_valid_o (word_valid_o),
    .bit_o        (bit_o),
    .bit_valid_o  (bit_valid_o),
    .err_o        (err_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int cyc; logic [3:0] word; logic [2:0] len; } wexp_t;
  typedef struct { int cyc; logic b; } bexp_t;
  wexp_t wq[$];
  bexp_t bq[$];
  int    eq[$];

  int   n_pass   = 0;
  int   n_checks = 0;
  logic level    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // mode 0: legal codeword, 1: expected code error, 2: partial (nothing expected)
  task automatic send(input logic [7:0] cw, input int n, input logic [3:0] word, input int len, input int mode);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk_i);
      level  = level ^ cw[i];
      en_i   = 1'b1;
      line_i = level;
    end
    if (mode == 0) begin
      wq.push_back('{cyc + 1, word, 3'(len)});
      for (int j = 0; j < len; j++) bq.push_back('{cyc + 2 + j, word[len - 1 - j]});
    end else if (mode == 1) begin
      eq.push_back(cyc + 1);
    end
  endtask

  task automatic idle(input int n, input bit flip);
    if (flip) level = ~level;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      en_i   = 1'b0;
      line_i = level;
    end
  endtask

  always @(negedge clk_i) begin
    wexp_t w;
    bexp_t b;
    int    e;
    if (!rst_i) begin
      if (word_valid_o) begin
        if (wq.size() == 0) check("word_unexpected", 32'(word_valid_o), 32'd0);
        else begin
          w = wq.pop_front();
          check("word_cycle", cyc, w.cyc);
          check("word", 32'(word_o), 32'(w.word));
          check("len", 32'(len_o), 32'(w.len));
        end
      end
      if (bit_valid_o) begin
        if (bq.size() == 0) check("bit_unexpected", 32'(bit_valid_o), 32'd0);
        else begin
          b = bq.pop_front();
          check("bit_cycle", cyc, b.cyc);
          check("bit", 32'(bit_o), 32'(b.b));
        end
      end
      if (err_o) begin
        if (eq.size() == 0) check("err_unexpected", 32'(err_o), 32'd0);
        else begin
          e = eq.pop_front();
          check("err_cycle", cyc, e);
        end
      end
    end
  end

  logic [7:0] cw_tab [7] = '{8'b1000, 8'b0100, 8'b001000, 8'b100100, 8'b000100, 8'b00001000, 8'b00100100};
  int         n_tab  [7] = '{4, 4, 6, 6, 6, 8, 8};
  logic [3:0] d_tab  [7] = '{4'b0011, 4'b0010, 4'b0011, 4'b0010, 4'b0000, 4'b0011, 4'b0010};
  int         l_tab  [7] = '{2, 2, 3, 3, 3, 4, 4};

  initial begin
    rst_i  = 1'b1;
    en_i   = 1'b0;
    line_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_word", 32'(word_o), 32'd0);
    check("rst_len", 32'(len_o), 32'd0);
    check("rst_word_valid", 32'(word_valid_o), 32'd0);
    check("rst_bit", 32'(bit_o), 32'd0);
    check("rst_bit_valid", 32'(bit_valid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_err_cnt", 32'(err_cnt_o), 32'd0);
    rst_i = 1'b0;

    // single 1000 -> 11
    send(8'b1000, 4, 4'b0011, 2, 0);
    idle(4, 1'b0);

    // 00100100 then 1000 back-to-back
    send(8'b00100100, 8, 4'b0010, 4, 0);
    send(8'b1000, 4, 4'b0011, 2, 0);
    idle(6, 1'b0);

    // all seven codewords, both line polarities
    for (int p = 0; p < 2; p++) begin
      idle(1, p == 1);
      for (int k = 0; k < 7; k++) send(cw_tab[k], n_tab[k], d_tab[k], l_tab[k], 0);
      idle(6, 1'b0);
    end

    // eight channel zeros -> one error, then 0100 -> 10
    send(8'b0, 8, 4'b0, 0, 1);
    idle(2, 1'b0);
    check("err_cnt_one", 32'(err_cnt_o), 32'd1);
    send(8'b0100, 4, 4'b0010, 2, 0);
    idle(4, 1'b0);

    // partial 100 dropped by en_i, then full 1000
    send(8'b100, 3, 4'b0, 0, 2);
    idle(1, 1'b0);
    send(8'b1000, 4, 4'b0011, 2, 0);
    idle(5, 1'b0);
    check("err_cnt_after_drop", 32'(err_cnt_o), 32'd1);

    // asynchronous reset in the middle of a serial drain
    send(8'b00001000, 8, 4'b0011, 4, 0);
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_bit_valid", 32'(bit_valid_o), 32'd0);
    check("mid_rst_bit", 32'(bit_o), 32'd0);
    check("mid_rst_word", 32'(word_o), 32'd0);
    check("mid_rst_len", 32'(len_o), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt_o), 32'd0);
    wq.delete();
    bq.delete();
    eq.delete();
    en_i   = 1'b0;
    line_i = 1'b0;
    level  = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(2, 1'b0);

    // error counter saturation
    for (int i = 0; i < 254; i++) send(8'b0, 8, 4'b0, 0, 1);
    idle(2, 1'b0);
    check("err_cnt_254", 32'(err_cnt_o), 32'd254);
    send(8'b0, 8, 4'b0, 0, 1);
    idle(2, 1'b0);
    check("err_cnt_255", 32'(err_cnt_o), 32'd255);
    for (int i = 0; i < 45; i++) send(8'b0, 8, 4'b0, 0, 1);
    idle(2, 1'b0);
    check("err_cnt_sat", 32'(err_cnt_o), 32'd255);
    send(8'b0100, 4, 4'b0010, 2, 0);
    idle(8, 1'b0);

    check("words_pending", wq.size(), 32'd0);
    check("bits_pending", bq.size(), 32'd0);
    check("errs_pending", eq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_rll.md
# decoder_rll

RLL(2,7) channel decoder. Samples one channel bit per `clk_i` from a serial line carrying transition-coded RLL(2,7) symbols and recovers the original data bits. A transition is a channel `1`; no transition is a `0`. Each recognised codeword is presented twice: once as a parallel word with a length, then as a serial bit stream. The block sits on the receive side of the RLL link, directly after the line sampler, and feeds data-bit consumers.

## Interface
- `ERR_CNT_W`, 8, width of the saturating code-error counter.
- `clk_i`  in  1  channel-bit clock; one channel bit per rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `en_i`  in  1  framing enable; the first channel bit sampled with `en_i`=1 after it was 0 starts a codeword.
- `line_i`  in  1  line level; transitions carry data.
- `word_o`  out  4  decoded data bits, first-received bit in `word_o[len-1]`, right-aligned.
- `len_o`  out  3  number of valid bits in `word_o`: 2, 3 or 4.
- `word_valid_o`  out  1  one-cycle strobe; `word_o`/`len_o` valid.
- `bit_o`  out  1  serial data bit.
- `bit_valid_o`  out  1  `bit_o` valid this cycle.
- `err_o`  out  1  one-cycle pulse on an illegal codeword.
- `err_cnt_o`  out  ERR_CNT_W  saturating count of `err_o` pulses.

## Operation
- Transition bit: `t = line_i ^ line_q`. `line_q` is updated every cycle regardless of `en_i`.
- Codeword register: 8-bit shift register `cw` plus a channel-bit counter `cnt` (0..8). While `en_i`=1, `t` is shifted in and `cnt` is incremented each cycle.
- Matching is done only when the post-shift `cnt` is 4, 6 or 8. The codes are prefix-free:
  - 4 bits: `1000` → `11`; `0100` → `10`
  - 6 bits: `001000` → `011`; `100100` → `010`; `000100` → `000`
  - 8 bits: `00001000` → `0011`; `00100100` → `0010`
- On a match: load `word_o`/`len_o`, pulse `word_valid_o`, clear `cnt`, load the serializer.
- If `cnt` reaches 8 with no match: pulse `err_o`, increment `err_cnt_o` (saturating at all-ones), clear `cnt`, load nothing.
- `en_i`=0 holds `cnt` at 0 and discards any partial codeword without raising an error. A serializer that is draining continues.
- Serializer: emits `len` bits, MSB-first (first received first), one per cycle, with `bit_valid_o` high.
- Overlap cannot occur on a legal stream: a word of at most 4 bits drains before the next codeword, at least 4 channel bits, completes. If a new word is loaded while draining, the new word replaces the remainder.

## Timing
- Reset values: `word_o`=0, `len_o`=0, `word_valid_o`=0, `bit_o`=0, `bit_valid_o`=0, `err_o`=0, `err_cnt_o`=0, `cnt`=0, `cw`=0, `line_q`=0.
- Reset takes effect immediately and asynchronously, including mid-codeword and mid-drain.
- Define edge N as the edge that samples the last channel bit of a codeword.
  - `word_valid_o` and `err_o` are high for exactly the cycle following edge N (registered, latency 1).
  - `bit_valid_o` is high for cycles N+2 … N+1+len.
- Back-to-back codewords need no idle gap. The first bit of the next codeword is sampled at edge N+1.
- An `en_i` rise at edge E makes the bit sampled at E channel bit 1.

## Structure
- `rll_pkg` holds:
  - codeword constants and decoded values for the seven entries;
  - the length enum (`LEN2`, `LEN3`, `LEN4`);
  - the max codeword width (8) and the max data width (4).
- Sub-module `rll_bit_serializer`: loads a 4-bit word and a length, shifts bits out MSB-first with a valid signal, and is overwritten on reload.
- The decoder holds the transition detect, the framing counter, the match logic and the error counter.

## Test plan
- Reset then `en_i`=1, `line_i`=0→1,1,1,1 (channel `1000`) → `word_valid_o` one cycle, `word_o`=`0011`, `len_o`=2; then `bit_o` = 1,1 on two consecutive valid cycles.
- Line levels 0,0,1,1,1,0,0,0 then 1,1,1,1 from `line_q`=0 (channels `00100100`, `1000`) → words `0010`/len 4, then `11`/len 2; serial 0,0,1,0,1,1 with no gap loss.
- All seven codewords sent back-to-back, each in both line polarities → correct words and lengths, `err_o` never pulses.
- 8 channel bits with no transition → `err_o` pulses once, `err_cnt_o`=1, no `word_valid_o`. A following `0100` decodes to `10`.
- `en_i` dropped after 3 channel bits of `100100`, then re-raised with a full `1000` → only `11` decoded, no error. A separate run with `rst_i` asserted mid-drain clears all outputs in the same cycle.
- 300 forced errors → `err_cnt_o` saturates at 255.
